// File: rtl/repeated_test.sv
// ----------------------------------------------------------------------------
// repeated_test -- sequential pattern replicator
//
// Concatenates the low pattern_size bits of pattern, timesRepeat times, into a
// OUT_W-bit word. Repetition 0 sits in the LSBs. One repetition is written per
// clock while in BUILD. Anything that would land at bit index >= OUT_W is
// dropped.
//
// Optional feature macro: REPEAT_OVF_EN
//   defined   -> extra registered output ovf, set when truncation discards
//                data and held until the next accepted start or rst.
//   undefined -> no ovf port; truncation is silent.
//
// Ports
//   clk             in   1       clock, rising edge
//   rst             in   1       synchronous active-high reset
//   start           in   1       one-cycle request, honoured only in IDLE
//   pattern         in   PAT_W   bits to replicate (low pattern_size used)
//   timesRepeat     in   CNT_W   repetition count
//   pattern_size    in   SIZE_W  repetition size in bits, valid 1..PAT_W
//   repeatedPattern out  OUT_W   result word (registered)
//   busy            out  1       high while in BUILD
//   done            out  1       one-cycle pulse when the result is final
//   err             out  1       pattern_size was invalid for this run
//   ovf             out  1       (REPEAT_OVF_EN only) result was truncated
// ----------------------------------------------------------------------------
module repeated_test #(
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 7,
  parameter int SIZE_W = 3,
  parameter int OUT_W  = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [CNT_W-1:0]  timesRepeat,
  input  logic [SIZE_W-1:0] pattern_size,
  output logic [OUT_W-1:0]  repeatedPattern,
`ifdef REPEAT_OVF_EN
  output logic              ovf,
`endif
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Bit pointer must hold OUT_W-1 + PAT_W without wrapping.
  localparam int P_W = $clog2(OUT_W + PAT_W + 1);

  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [PAT_W-1:0]  pat_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [SIZE_W-1:0] size_reg;
  logic [CNT_W-1:0]  k_reg;
  logic [P_W-1:0]    p_reg;
  logic [OUT_W-1:0]  word_reg;
  logic              done_reg;
  logic              err_reg;

  logic              size_bad;
  logic [PAT_W-1:0]  pat_bits;
  logic [OUT_W-1:0]  rep_word;
  logic [P_W-1:0]    p_sum;
  logic [CNT_W:0]    k_sum;
  logic              last_rep;
  logic              trunc;

  assign size_bad = (pattern_size == '0) || (pattern_size > SIZE_W'(PAT_W));

  // Keep only the low size_reg pattern bits.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign pat_bits[gi] = pat_reg[gi] & (size_reg > SIZE_W'(gi));
  end

  // Bits shifted past OUT_W-1 fall off the top, which is the truncation.
  assign rep_word = OUT_W'(pat_bits) << p_reg;
  assign p_sum    = p_reg + P_W'(size_reg);
  assign k_sum    = {1'b0, k_reg} + 1'b1;
  assign last_rep = (k_sum == {1'b0, cnt_reg}) || (p_sum >= P_W'(OUT_W));
  // Data is lost if this repetition spills over the top, or if the word is
  // exactly full but repetitions remain.
  assign trunc    = (p_sum > P_W'(OUT_W)) ||
                    ((p_sum >= P_W'(OUT_W)) && (k_sum < {1'b0, cnt_reg}));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (size_bad || (timesRepeat == '0)) state_next = DONE;
          else                                 state_next = BUILD;
        end
      end
      BUILD: begin
        if (last_rep) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef REPEAT_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if ((state_reg == IDLE) && start) begin
      ovf_reg <= 1'b0;
    end else if ((state_reg == BUILD) && trunc) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_trunc;
  assign unused_trunc = trunc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      cnt_reg   <= '0;
      size_reg  <= '0;
      k_reg     <= '0;
      p_reg     <= '0;
      word_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      // done follows the DONE state by one cycle so the pulse coincides
      // with the final word being visible.
      done_reg  <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            pat_reg  <= pattern;
            cnt_reg  <= timesRepeat;
            size_reg <= pattern_size;
            k_reg    <= '0;
            p_reg    <= '0;
            word_reg <= '0;
            err_reg  <= size_bad;
          end
        end
        BUILD: begin
          // Earlier repetitions occupy disjoint bits, so OR-in is exact.
          word_reg <= word_reg | rep_word;
          p_reg    <= p_sum;
          k_reg    <= k_sum[CNT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign repeatedPattern = word_reg;
  assign busy            = (state_reg == BUILD);
  assign done            = done_reg;
  assign err             = err_reg;

endmodule

// File: tb/tb_repeated_test.sv
module tb_repeated_test;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   pattern;
  logic [6:0]   timesRepeat;
  logic [2:0]   pattern_size;
  logic [299:0] repeatedPattern;
  logic         busy;
  logic         done;
  logic         err;
`ifdef REPEAT_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  repeated_test dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pattern         (pattern),
    .timesRepeat     (timesRepeat),
    .pattern_size    (pattern_size),
    .repeatedPattern (repeatedPattern),
`ifdef REPEAT_OVF_EN
    .ovf             (ovf),
`endif
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the result is N copies of the S-bit slice, laid out from bit 0,
  // with N limited by what fits in 300 bits.
  function automatic int exp_reps(input int t, input int s);
    int fit;
    if (s < 1 || s > 4) return 0;
    fit = (300 + s - 1) / s;
    return (t < fit) ? t : fit;
  endfunction

  function automatic logic [299:0] exp_word(input logic [3:0] pat, input int t, input int s);
    logic [299:0] w;
    int n;
    w = '0;
    n = exp_reps(t, s);
    for (int j = 0; j < n * s && j < 300; j++) w[j] = pat[j % s];
    return w;
  endfunction

  // One full transaction; optionally fires a second start mid-build.
  task automatic run(input logic [3:0] pat, input int t, input int s, input bit glitch);
    int           lat, exp_lat;
    bit           seen;
    logic [299:0] exp_w;
    exp_w   = exp_word(pat, t, s);
    exp_lat = (s < 1 || s > 4 || t == 0) ? 1 : exp_reps(t, s) + 1;
    @(negedge clk);
    pattern      = pat;
    timesRepeat  = 7'(t);
    pattern_size = 3'(s);
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs wander after acceptance; the latched copy must be used.
    pattern      = 4'($urandom);
    timesRepeat  = 7'($urandom);
    pattern_size = 3'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      start = glitch && (cyc == 5);
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 300'(seen), 300'(1));
    check("latency", 300'(lat), 300'(exp_lat));
    check("word", repeatedPattern, exp_w);
    check("err", 300'(err), 300'((s < 1 || s > 4) ? 1 : 0));
`ifdef REPEAT_OVF_EN
    check("ovf", 300'(ovf), 300'((s >= 1 && s <= 4 && t * s > 300) ? 1 : 0));
`endif
    @(posedge clk);
    #1;
    check("done_pulse_end", 300'(done), 300'(0));
    check("word_held", repeatedPattern, exp_w);
    $display("run pat=%b t=%0d s=%0d glitch=%0d lat=%0d exp_lat=%0d", pat, t, s, glitch, lat, exp_lat);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pattern      = '0;
    timesRepeat  = '0;
    pattern_size = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", repeatedPattern, '0);
    check("rst_busy", 300'(busy), 300'(0));
    check("rst_done", 300'(done), 300'(0));
    check("rst_err", 300'(err), 300'(0));
    rst = 1'b0;

    // Directed cases.
    run(4'b1100, 75, 4, 1'b0);
    run(4'b0101, 10, 3, 1'b0);
    run(4'b1010, 100, 4, 1'b0);
    run(4'b0110, 0, 2, 1'b0);
    run(4'b1111, 20, 0, 1'b0);
    run(4'b1111, 20, 5, 1'b0);
    run(4'b0001, 127, 1, 1'b0);
    run(4'b1011, 127, 3, 1'b0);
    run(4'b1001, 40, 2, 1'b1);

    // Abort in the middle of a build.
    @(negedge clk);
    pattern = 4'b1100; timesRepeat = 7'd75; pattern_size = 3'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("busy_before_rst", 300'(busy), 300'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_word", repeatedPattern, '0);
    check("abort_busy", 300'(busy), 300'(0));
    check("abort_done", 300'(done), 300'(0));
    check("abort_err", 300'(err), 300'(0));
`ifdef REPEAT_OVF_EN
    check("abort_ovf", 300'(ovf), 300'(0));
`endif
    $display("abort at build cycle 20 done");
    run(4'b0011, 30, 4, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      int t, s;
      s = int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       t = int'($urandom_range(0, 3));
        1:       t = int'($urandom_range(60, 127));
        default: t = int'($urandom_range(0, 127));
      endcase
      run(4'($urandom), t, s, (t >= 10 && s >= 1 && s <= 4) ? 1'($urandom) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
